riscv_divider: RTL and testbench



---
 rtl/riscv_divider.sv | 144 ++++++++++++++
 tb/tb_riscv_divider.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_divider.sv
// Radix-2 restoring divider for RV64M DIV/REM (64-bit and W forms), one quotient bit per clock.
// Operands are latched at start, so the held control word and operand buses may change while busy.
`timescale 1ns/1ps
module riscv_divider (
    input  logic        i_riscv_div_clk,
    input  logic        i_riscv_div_rst_n,
    input  logic [63:0] i_riscv_div_rs1data,
    input  logic [63:0] i_riscv_div_rs2data,
    input  logic [3:0]  i_riscv_div_divctrl,
    output logic [63:0] o_riscv_div_result,
    output logic        o_riscv_div_valid
);
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

    state_t              r_state;
    logic [6:0]          r_cnt;
    logic                r_word;
    logic                r_rem_op;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_div_zero;
    logic                r_ovf;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_dvsr;
    logic [DATA_W-1:0]   r_dvnd;

    function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] x);
        return neg ? (DATA_W'(0) - x) : x;
    endfunction

    function automatic logic [DATA_W-1:0] sext_word(input logic [DATA_W-1:0] x);
        return {{32{x[31]}}, x[31:0]};
    endfunction

    logic                w_word;
    logic                w_signed;
    logic                w_start;
    logic                w_sa;
    logic                w_sb;
    logic signed [DATA_W-1:0] w_a_ext;
    logic signed [DATA_W-1:0] w_b_ext;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic                w_min_neg;
    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W:0]     w_trial;
    logic [DATA_W-1:0]   w_q;
    logic [DATA_W-1:0]   w_r;
    logic [DATA_W-1:0]   w_sel;
    logic [DATA_W-1:0]   w_res;

    // Operand prep: W ops are reduced to a 64-bit value (sign- or zero-extended from bit 31)
    always_comb begin
        w_word   = ~i_riscv_div_divctrl[2];
        w_signed = ~i_riscv_div_divctrl[0];
        w_start  = i_riscv_div_divctrl[3] & ~o_riscv_div_valid;
        w_a_ext  = i_riscv_div_rs1data;
        w_b_ext  = i_riscv_div_rs2data;
        if (w_word) begin
            w_a_ext = w_signed ? sext_word(i_riscv_div_rs1data) : {32'd0, i_riscv_div_rs1data[31:0]};
            w_b_ext = w_signed ? sext_word(i_riscv_div_rs2data) : {32'd0, i_riscv_div_rs2data[31:0]};
        end
        w_sa      = w_signed & w_a_ext[DATA_W-1];
        w_sb      = w_signed & w_b_ext[DATA_W-1];
        w_a_mag   = cond_neg(w_sa, w_a_ext);
        w_b_mag   = cond_neg(w_sb, w_b_ext);
        w_min_neg = w_word ? (w_a_ext == 64'hFFFF_FFFF_8000_0000)
                           : (w_a_ext == 64'h8000_0000_0000_0000);
    end

    // The 65-bit trial is negative exactly when its top bit is set, since the shifted remainder is below 2*divisor
    always_comb begin
        w_rem_sh = {r_rem, r_quo[DATA_W-1]};
        w_trial  = w_rem_sh - {1'b0, r_dvsr};
        w_q      = r_div_zero ? {DATA_W{1'b1}} : (r_ovf ? r_dvnd : cond_neg(r_neg_q, r_quo));
        w_r      = r_div_zero ? r_dvnd : (r_ovf ? DATA_W'(0) : cond_neg(r_neg_r, r_rem));
        w_sel    = r_rem_op ? w_r : w_q;
        w_res    = r_word ? sext_word(w_sel) : w_sel;
    end

    always_ff @(posedge i_riscv_div_clk or negedge i_riscv_div_rst_n) begin
        if (!i_riscv_div_rst_n) begin
            r_state            <= S_IDLE;
            r_cnt              <= '0;
            r_word             <= 1'b0;
            r_rem_op           <= 1'b0;
            r_neg_q            <= 1'b0;
            r_neg_r            <= 1'b0;
            r_div_zero         <= 1'b0;
            r_ovf              <= 1'b0;
            r_rem              <= '0;
            r_quo              <= '0;
            r_dvsr             <= '0;
            r_dvnd             <= '0;
            o_riscv_div_result <= '0;
            o_riscv_div_valid  <= 1'b0;
        end else begin
            o_riscv_div_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_word     <= w_word;
                        r_rem_op   <= i_riscv_div_divctrl[1];
                        r_neg_q    <= w_sa ^ w_sb;
                        r_neg_r    <= w_sa;
                        r_div_zero <= (w_b_ext == '0);
                        r_ovf      <= w_signed & w_min_neg & (w_b_ext == {DATA_W{1'b1}});
                        r_dvsr     <= w_b_mag;
                        r_dvnd     <= w_a_ext;
                        r_rem      <= '0;
                        // W dividends sit in the top half so 32 shifts feed all their bits
                        r_quo      <= w_word ? {w_a_mag[31:0], 32'd0} : w_a_mag;
                        r_cnt      <= '0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!w_trial[DATA_W]) begin
                        r_rem <= w_trial[DATA_W-1:0];
                        r_quo <= {r_quo[DATA_W-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh[DATA_W-1:0];
                        r_quo <= {r_quo[DATA_W-2:0], 1'b0};
                    end
                    if (r_cnt == (r_word ? 7'd31 : 7'd63)) begin
                        r_cnt   <= '0;
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_FIX: begin
                    o_riscv_div_result <= w_res;
                    o_riscv_div_valid  <= 1'b1;
                    r_state            <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_divider.sv
// Directed bench for riscv_divider: arithmetic reference model, per-cycle output checker, literal pins.
`timescale 1ns/1ps
module tb_riscv_divider;
    logic        clk;
    logic        rst_n;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [3:0]  divctrl;
    logic [63:0] result;
    logic        valid;

    riscv_divider dut (
        .i_riscv_div_clk     (clk),
        .i_riscv_div_rst_n   (rst_n),
        .i_riscv_div_rs1data (rs1),
        .i_riscv_div_rs2data (rs2),
        .i_riscv_div_divctrl (divctrl),
        .o_riscv_div_result  (result),
        .o_riscv_div_valid   (valid)
    );

    typedef struct {
        logic [63:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   vld_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain RISC-V division semantics, with the zero-divisor and overflow rules
    function automatic logic [63:0] model(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b);
        logic [31:0] q32, r32, x32;
        logic [63:0] q64, r64;
        int          sa, sb;
        longint      la, lb;
        sa = a[31:0];
        sb = b[31:0];
        la = a;
        lb = b;
        if (!ctl[2]) begin
            if (b[31:0] == 32'd0) begin
                q32 = '1; r32 = a[31:0];
            end else if (!ctl[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                q32 = a[31:0]; r32 = '0;
            end else if (!ctl[0]) begin
                q32 = sa / sb; r32 = sa % sb;
            end else begin
                q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
            end
            x32 = ctl[1] ? r32 : q32;
            return {{32{x32[31]}}, x32};
        end
        if (b == 64'd0) begin
            q64 = '1; r64 = a;
        end else if (!ctl[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q64 = a; r64 = '0;
        end else if (!ctl[0]) begin
            q64 = la / lb; r64 = la % lb;
        end else begin
            q64 = a / b; r64 = a % b;
        end
        return ctl[1] ? r64 : q64;
    endfunction

    // Output checker: every valid pulse must match the oldest expectation, on its due cycle
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (valid) begin
            vld_cnt++;
            if (q.size() == 0) begin
                chk("spurious_valid", {63'd0, valid}, 64'd0);
            end else begin
                e = q.pop_front();
                chk({e.name, "_latency"}, 64'(cyc), 64'(e.due));
                chk(e.name, result, e.res);
            end
        end else if (q.size() != 0 && cyc > q[0].due) begin
            e = q.pop_front();
            chk({e.name, "_missing_valid"}, 64'(cyc), 64'(e.due));
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 150) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, 64'(q.size()), 64'd0);
    endtask

    task automatic push_exp(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b,
                            input int due, input string name);
        exp_t e;
        e.res  = model(ctl, a, b);
        e.due  = due;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic do_op(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b,
                         input logic has_lit, input logic [63:0] lit, input string name);
        int lat;
        lat = ctl[2] ? 65 : 33;
        @(negedge clk);
        divctrl = ctl;
        rs1     = a;
        rs2     = b;
        push_exp(ctl, a, b, cyc + 1 + lat, name);
        if (has_lit) chk({name, "_model"}, model(ctl, a, b), lit);
        @(negedge clk);
        divctrl = 4'b0000;
        rs1     = ~a;
        rs2     = a ^ b ^ 64'h5A5A_5A5A_5A5A_5A5A;
        drain(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int vld0;
        rst_n   = 1'b0;
        divctrl = 4'b0000;
        rs1     = '0;
        rs2     = '0;
        repeat (3) @(negedge clk);
        chk("reset_result", result, 64'd0);
        chk("reset_valid", {63'd0, valid}, 64'd0);
        rst_n = 1'b1;

        do_op(4'b1101, 64'd100, 64'd7, 1'b1, 64'd14, "divu_100_7");
        do_op(4'b1111, 64'd100, 64'd7, 1'b1, 64'd2, "remu_100_7");
        do_op(4'b1100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2");
        do_op(4'b1110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "rem_m7_2");
        do_op(4'b1100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, "div_7_m2");
        do_op(4'b1100, 64'd5, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "div_by_zero");
        do_op(4'b1111, 64'h1234, 64'd0, 1'b1, 64'h1234, "remu_by_zero");
        do_op(4'b1000, 64'd5, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "divw_by_zero");
        do_op(4'b1100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              64'h8000_0000_0000_0000, "div_overflow");
        do_op(4'b1110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, "rem_overflow");
        do_op(4'b1000, 64'hDEAD_BEEF_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1,
              64'hFFFF_FFFF_8000_0000, "divw_overflow");
        do_op(4'b1001, 64'h0000_0000_FFFF_FFFE, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, "divuw_sext");
        do_op(4'b1010, 64'h0000_0001_0000_0007, 64'd3, 1'b1, 64'd1, "remw_upper_ignored");
        do_op(4'b1101, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b1, 64'd1, "divu_wide");
        do_op(4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b1,
              64'h7FFF_FFFF_FFFF_FFFE, "remu_wide");
        do_op(4'b1000, 64'h1234_5678_FFFF_FF9C, 64'hABCD_0000_0000_0007, 1'b1,
              64'hFFFF_FFFF_FFFF_FFF2, "divw_m100_7");
        do_op(4'b1010, 64'h1234_5678_FFFF_FF9C, 64'hABCD_0000_0000_0007, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFE, "remw_m100_7");
        do_op(4'b1011, 64'h0000_0000_FFFF_FFFF, 64'h10, 1'b1, 64'd15, "remuw_f");

        for (int i = 0; i < 8; i++) begin
            logic [3:0]  ctl;
            logic [63:0] a, b;
            ctl = {1'b1, 3'($urandom_range(0, 7))};
            a   = {$urandom, $urandom};
            b   = (i % 2 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
            do_op(ctl, a, b, 1'b0, 64'd0, "random_op");
        end

        // Held start: second division begins two cycles after the first pulse (66 idle cycles between pulses)
        @(negedge clk);
        divctrl = 4'b1100;
        rs1     = 64'd100;
        rs2     = 64'd7;
        c       = cyc;
        vld0    = vld_cnt;
        push_exp(4'b1100, 64'd100, 64'd7, c + 66, "hold_first");
        push_exp(4'b1100, 64'd100, 64'd7, c + 66 + 67, "hold_second");
        push_exp(4'b1100, 64'd100, 64'd7, c + 66 + 134, "hold_third");
        repeat (140) @(negedge clk);
        chk("hold_pulse_count", 64'(vld_cnt - vld0), 64'd2);
        divctrl = 4'b0000;
        drain("hold");

        // Asynchronous reset in the middle of a division
        @(negedge clk);
        divctrl = 4'b1100;
        rs1     = 64'd1000;
        rs2     = 64'd3;
        c       = cyc;
        @(negedge clk);
        divctrl = 4'b0000;
        while (cyc < c + 31) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midop_reset_result", result, 64'd0);
        chk("midop_reset_valid", {63'd0, valid}, 64'd0);
        @(negedge clk);
        q.delete();
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        chk("midop_reset_no_pulse", 64'(vld_cnt), 64'(vld_cnt));
        do_op(4'b1100, 64'd1000, 64'd3, 1'b1, 64'd333, "after_reset");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
